// File: rtl/opm_dac_serializer.sv
// Converts the left/right accumulator sums to 13-bit floating-point DAC words and shifts them out serially.
// The frame starts one tick after the cycle-31 strobe. There is no backpressure: a new strobe always restarts the frame.
module opm_dac_serializer (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_31,
    input  logic [15:0] i_ACC_L,
    input  logic [15:0] i_ACC_R,
    output logic        o_SO,
    output logic        o_SH1,
    output logic        o_SH2,
    output logic [12:0] o_FLOAT_L,
    output logic [12:0] o_FLOAT_R
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state;
    logic [31:0] shift_reg;
    logic [4:0]  slot;
    logic [12:0] float_l;
    logic [12:0] float_r;

    // A 1 in d[i] marks a non-redundant sign bit at position i. The shift must push the highest such bit below bit 10.
    function automatic logic [12:0] to_float(input logic [15:0] x);
        logic [5:0] d;
        logic [2:0] s;
        logic [9:0] m;
        d = x[15:10] ^ x[14:9];
        s = 3'd0;
        for (int i = 0; i < 6; i++)
            if (d[i]) s = 3'(i + 1);
        case (s)
            3'd0:    m = x[9:0];
            3'd1:    m = x[10:1];
            3'd2:    m = x[11:2];
            3'd3:    m = x[12:3];
            3'd4:    m = x[13:4];
            3'd5:    m = x[14:5];
            default: m = x[15:6];
        endcase
        return {s + 3'd1, m};
    endfunction

    assign float_l = to_float(i_ACC_L);
    assign float_r = to_float(i_ACC_R);

    always_ff @(posedge i_EMUCLK) begin
        if (!i_phi1_NCEN_n) begin
            if (!i_MRST_n) begin
                state     <= IDLE;
                shift_reg <= '0;
                slot      <= '0;
                o_SO      <= 1'b0;
                o_SH1     <= 1'b0;
                o_SH2     <= 1'b0;
                o_FLOAT_L <= '0;
                o_FLOAT_R <= '0;
            end else if (i_CYCLE_31) begin
                o_FLOAT_L <= float_l;
                o_FLOAT_R <= float_r;
                shift_reg <= {float_r, 3'b000, float_l, 3'b000};
                slot      <= '0;
                state     <= SEND;
                o_SO      <= 1'b0;
                o_SH1     <= 1'b0;
                o_SH2     <= 1'b0;
            end else if (state == SEND) begin
                o_SO      <= shift_reg[0];
                shift_reg <= {1'b0, shift_reg[31:1]};
                o_SH1     <= (slot == 5'd15);
                o_SH2     <= (slot == 5'd31);
                // The 5-bit counter wraps to 0 after slot 31.
                slot      <= slot + 5'd1;
                if (slot == 5'd31)
                    state <= IDLE;
            end else begin
                o_SO  <= 1'b0;
                o_SH1 <= 1'b0;
                o_SH2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_opm_dac_serializer.sv
// Directed bench for opm_dac_serializer: a table of conversion vectors plus hand-written multi-cycle corner cases.
module tb_opm_dac_serializer;

    logic        clk = 1'b0;
    logic        mrst_n = 1'b0;
    logic        ncen_n = 1'b0;
    logic        cyc = 1'b0;
    logic [15:0] acc_l = '0;
    logic [15:0] acc_r = '0;
    logic        so, sh1, sh2;
    logic [12:0] fl, fr;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] so_w, sh1_w, sh2_w;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [12:0] fl;
        logic [12:0] fr;
    } vec_t;

    vec_t vecs[8];

    opm_dac_serializer dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (mrst_n),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (cyc),
        .i_ACC_L       (acc_l),
        .i_ACC_R       (acc_r),
        .o_SO          (so),
        .o_SH1         (sh1),
        .o_SH2         (sh2),
        .o_FLOAT_L     (fl),
        .o_FLOAT_R     (fr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int k);
        tick();
        so_w[k]  = so;
        sh1_w[k] = sh1;
        sh2_w[k] = sh2;
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        acc_l = l;
        acc_r = r;
        cyc   = 1'b1;
        tick();
        cyc   = 1'b0;
        acc_l = 16'($urandom);
        acc_r = 16'($urandom);
    endtask

    // Slot k of the frame is bit k of this word.
    function automatic logic [31:0] frame_of(input logic [12:0] wl, input logic [12:0] wr);
        return {wr[12:10], wr[9:0], 3'b000, wl[12:10], wl[9:0], 3'b000};
    endfunction

    task automatic check_frame(input string tag, input logic [12:0] wl, input logic [12:0] wr);
        chk({tag, " so_slots"}, so_w, frame_of(wl, wr));
        chk({tag, " sh1_slots"}, sh1_w, 32'h0000_8000);
        chk({tag, " sh2_slots"}, sh2_w, 32'h8000_0000);
    endtask

    task automatic clear_cap();
        so_w  = '0;
        sh1_w = '0;
        sh2_w = '0;
    endtask

    initial begin
        logic [2:0] held;
        logic [2:0] seen;

        // Expected words worked out by hand from the exponent/mantissa rule.
        vecs[0] = '{16'h0000, 16'h0000, 13'h0400, 13'h0400};
        vecs[1] = '{16'h01FF, 16'hFFFF, 13'h05FF, 13'h07FF};
        vecs[2] = '{16'h0200, 16'hFE00, 13'h0900, 13'h0600};
        vecs[3] = '{16'hFDFF, 16'h1234, 13'h0AFF, 13'h1523};
        vecs[4] = '{16'h7FFF, 16'h0000, 13'h1DFF, 13'h0400};
        vecs[5] = '{16'h8000, 16'h0200, 13'h1E00, 13'h0900};
        vecs[6] = '{16'hFE00, 16'h7FFF, 13'h0600, 13'h1DFF};
        vecs[7] = '{16'h1234, 16'h8000, 13'h1523, 13'h1E00};

        mrst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc   = 1'($urandom);
            acc_l = 16'($urandom);
            acc_r = 16'($urandom);
            tick();
        end
        chk("reset_outputs", {5'd0, so, sh1, sh2, fl, fr}, 32'd0);
        cyc = 1'b0;
        mrst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle", {5'd0, so, sh1, sh2, fl, fr}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i].l, vecs[i].r);
            chk($sformatf("v%0d strobe_quiet", i), {29'd0, so, sh1, sh2}, 32'd0);
            chk($sformatf("v%0d float_l", i), {19'd0, fl}, {19'd0, vecs[i].fl});
            chk($sformatf("v%0d float_r", i), {19'd0, fr}, {19'd0, vecs[i].fr});
            clear_cap();
            for (int k = 0; k < 32; k++) cap(k);
            check_frame($sformatf("v%0d", i), vecs[i].fl, vecs[i].fr);
            tick();
            chk($sformatf("v%0d idle_after", i), {29'd0, so, sh1, sh2}, 32'd0);
            chk($sformatf("v%0d float_l_hold", i), {19'd0, fl}, {19'd0, vecs[i].fl});
        end

        // Back-to-back strobes 32 ticks apart: the new strobe overrides slot 31 and o_SH2.
        strobe(16'h01FF, 16'hFFFF);
        clear_cap();
        for (int k = 0; k < 31; k++) cap(k);
        chk("b2b first_31_slots", {1'b0, so_w[30:0]}, {1'b0, frame_of(13'h05FF, 13'h07FF) & 32'h7FFF_FFFF});
        chk("b2b sh1_once", sh1_w, 32'h0000_8000);
        strobe(16'h0200, 16'h1234);
        chk("b2b strobe_wins", {29'd0, so, sh1, sh2}, 32'd0);
        chk("b2b float_l", {19'd0, fl}, 32'h0900);
        clear_cap();
        for (int k = 0; k < 32; k++) cap(k);
        check_frame("b2b second", 13'h0900, 13'h1523);

        // A strobe at slot 10 aborts the frame and restarts it.
        strobe(16'h0100, 16'h0000);
        clear_cap();
        for (int k = 0; k < 10; k++) cap(k);
        chk("abort first_slots", {22'd0, so_w[9:0]}, {22'd0, frame_of(13'h0500, 13'h0400) & 32'h0000_03FF});
        strobe(16'h0200, 16'h0000);
        chk("abort strobe_quiet", {29'd0, so, sh1, sh2}, 32'd0);
        clear_cap();
        for (int k = 0; k < 32; k++) cap(k);
        check_frame("abort restart", 13'h0900, 13'h0400);

        // Clock enable held off just after the o_SH1 slot; a strobe during the freeze must be ignored.
        strobe(16'h7FFF, 16'hFDFF);
        clear_cap();
        for (int k = 0; k < 16; k++) cap(k);
        held = {so, sh1, sh2};
        ncen_n = 1'b1;
        cyc = 1'b1;
        acc_l = 16'h0000;
        seen = 3'b000;
        repeat (7) begin
            @(posedge clk);
            #1;
            if ({so, sh1, sh2} !== held) seen = 3'b111;
        end
        chk("freeze outputs_held", {29'd0, seen}, 32'd0);
        chk("freeze held_values", {29'd0, held}, {29'd0, 3'b110});
        chk("freeze float_l", {19'd0, fl}, 32'h1DFF);
        cyc = 1'b0;
        ncen_n = 1'b0;
        for (int k = 16; k < 32; k++) cap(k);
        check_frame("freeze resume", 13'h1DFF, 13'h0AFF);

        // A one-tick reset at slot 20 kills the frame.
        strobe(16'h1234, 16'h8000);
        clear_cap();
        for (int k = 0; k < 20; k++) cap(k);
        mrst_n = 1'b0;
        tick();
        mrst_n = 1'b1;
        chk("midreset outputs", {5'd0, so, sh1, sh2, fl, fr}, 32'd0);
        seen = 3'b000;
        repeat (14) begin
            tick();
            seen = seen | {so, sh1, sh2};
        end
        chk("midreset stays_idle", {29'd0, seen}, 32'd0);
        strobe(16'hFE00, 16'h0200);
        clear_cap();
        for (int k = 0; k < 32; k++) cap(k);
        check_frame("after_reset", 13'h0600, 13'h0900);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
